cache_arbiter: RTL and testbench

- Two-port arbiter that shares the single physical-memory (pmem) line port between the instruction cache and the data cache.
- The I-side requester is read-only. The D-side requester does reads (line fill) and writes (writeback).
- Latches the winning request, drives pmem until pmem_resp, then routes the response back to the winner.
- Round-robin on simultaneous requests; sits between the two cache controllers and the memory/burst interface.

---
 rtl/cache_arbiter_if.sv | 37 +++
 rtl/cache_arbiter.sv | 124 ++++++++++++
 tb/tb_cache_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_if.sv
// Bundle of the I-cache, D-cache and physical-memory line ports shared by the arbiter.
// The slave modport is the arbiter's view; master is the view of the surrounding caches and memory.
interface cache_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    logic [ADDR_WIDTH-1:0] imem_address;
    logic                  imem_read;
    logic [LINE_WIDTH-1:0] imem_rdata;
    logic                  imem_resp;
    logic [ADDR_WIDTH-1:0] dmem_address;
    logic                  dmem_read;
    logic                  dmem_write;
    logic [LINE_WIDTH-1:0] dmem_wdata;
    logic [LINE_WIDTH-1:0] dmem_rdata;
    logic                  dmem_resp;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic                  pmem_read;
    logic                  pmem_write;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  imem_address, imem_read, dmem_address, dmem_read, dmem_write, dmem_wdata,
        input  pmem_rdata, pmem_resp,
        output imem_rdata, imem_resp, dmem_rdata, dmem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata
    );

    modport master (
        output imem_address, imem_read, dmem_address, dmem_read, dmem_write, dmem_wdata,
        output pmem_rdata, pmem_resp,
        input  imem_rdata, imem_resp, dmem_rdata, dmem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one pmem line port between the I-cache (read-only) and D-cache.
// The winner's request is latched in s_idle and replayed to pmem until pmem_resp.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input logic             clk,
    input logic             rst,
    cache_arbiter_if.slave  bus
);
    localparam logic [1:0] s_idle       = 2'd0;
    localparam logic [1:0] s_serve_i    = 2'd1;
    localparam logic [1:0] s_serve_d_rd = 2'd2;
    localparam logic [1:0] s_serve_d_wr = 2'd3;
    localparam logic       GRANT_I      = 1'b0;
    localparam logic       GRANT_D      = 1'b1;

    logic [1:0]            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  i_req_s, d_req_s, grant_i_s;
    logic                  pmem_read_s, pmem_write_s, imem_resp_s, dmem_resp_s;
    logic [ADDR_WIDTH-1:0] pmem_address_s;
    logic [LINE_WIDTH-1:0] pmem_wdata_s;

    // Next-state: arbitration in s_idle, wait for pmem_resp while serving.
    always_comb begin
        i_req_s      = bus.imem_read;
        d_req_s      = bus.dmem_read | bus.dmem_write;
        grant_i_s    = i_req_s & (~d_req_s | (last_grant_q == GRANT_D));
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            s_idle: begin
                if (grant_i_s) begin
                    state_d      = s_serve_i;
                    last_grant_d = GRANT_I;
                    addr_d       = bus.imem_address;
                    wdata_d      = {LINE_WIDTH{1'b0}};
                end else if (d_req_s) begin
                    last_grant_d = GRANT_D;
                    addr_d       = bus.dmem_address;
                    // read+write together is illegal; writeback wins so no dirty data is lost
                    if (bus.dmem_write) begin
                        state_d = s_serve_d_wr;
                        wdata_d = bus.dmem_wdata;
                    end else begin
                        state_d = s_serve_d_rd;
                        wdata_d = {LINE_WIDTH{1'b0}};
                    end
                end else begin
                    state_d = s_idle;
                end
            end
            s_serve_i, s_serve_d_rd, s_serve_d_wr: begin
                if (bus.pmem_resp) begin
                    state_d = s_idle;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = s_idle;
        endcase
    end

    // State and latched-request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= s_idle;
            last_grant_q <= GRANT_D;
            addr_q       <= {ADDR_WIDTH{1'b0}};
            wdata_q      <= {LINE_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // pmem drive from latched copies only; resp routed to the winner in the pmem_resp cycle.
    always_comb begin
        pmem_read_s    = 1'b0;
        pmem_write_s   = 1'b0;
        imem_resp_s    = 1'b0;
        dmem_resp_s    = 1'b0;
        pmem_address_s = {ADDR_WIDTH{1'b0}};
        pmem_wdata_s   = {LINE_WIDTH{1'b0}};
        case (state_q)
            s_serve_i: begin
                pmem_read_s    = 1'b1;
                pmem_address_s = addr_q;
                imem_resp_s    = bus.pmem_resp;
            end
            s_serve_d_rd: begin
                pmem_read_s    = 1'b1;
                pmem_address_s = addr_q;
                dmem_resp_s    = bus.pmem_resp;
            end
            s_serve_d_wr: begin
                pmem_write_s   = 1'b1;
                pmem_address_s = addr_q;
                pmem_wdata_s   = wdata_q;
                dmem_resp_s    = bus.pmem_resp;
            end
            default: begin
                pmem_read_s    = 1'b0;
                pmem_write_s   = 1'b0;
            end
        endcase
    end

    assign bus.pmem_read    = pmem_read_s;
    assign bus.pmem_write   = pmem_write_s;
    assign bus.pmem_address = pmem_address_s;
    assign bus.pmem_wdata   = pmem_wdata_s;
    assign bus.imem_resp    = imem_resp_s;
    assign bus.dmem_resp    = dmem_resp_s;
    assign bus.imem_rdata   = bus.pmem_rdata;
    assign bus.dmem_rdata   = bus.pmem_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: table of single-requester transactions plus
// hand-written sequences for reset, round-robin, latching and spurious responses.
module tb_cache_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();
    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic          is_d;
        logic [LW-1:0] rdata;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic          i_rd, d_rd, d_wr;
        logic [AW-1:0] i_addr, d_addr;
        logic [LW-1:0] wdata, rdata;
        int            delay;
        logic          exp_read, exp_write, exp_is_d;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_wdata;
    } vec_t;
    vec_t vt[5];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic c1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic ca(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cw(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        c1({tag, " pmem_read"}, bus.pmem_read, 1'b0);
        c1({tag, " pmem_write"}, bus.pmem_write, 1'b0);
        ca({tag, " pmem_address"}, bus.pmem_address, 32'h0);
        cw({tag, " pmem_wdata"}, bus.pmem_wdata, {LW{1'b0}});
        c1({tag, " imem_resp"}, bus.imem_resp, 1'b0);
        c1({tag, " dmem_resp"}, bus.dmem_resp, 1'b0);
    endtask

    task automatic drop_reqs();
        bus.imem_read  = 1'b0;
        bus.dmem_read  = 1'b0;
        bus.dmem_write = 1'b0;
    endtask

    // Drive pmem_resp at a negedge, check the routed response, then check the idle cycle after.
    task automatic resp_cycle(input logic [LW-1:0] rd, input logic drop);
        exp_t e;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rd;
        if (drop) drop_reqs();
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL scoreboard: response cycle with no expected entry");
        end else begin
            e = sb.pop_front();
            c1("imem_resp", bus.imem_resp, ~e.is_d);
            c1("dmem_resp", bus.dmem_resp, e.is_d);
            if (e.is_d) cw("dmem_rdata", bus.dmem_rdata, e.rdata);
            else        cw("imem_rdata", bus.imem_rdata, e.rdata);
        end
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        #1;
        check_idle("post-resp idle");
    endtask

    function automatic vec_t mk(input logic i_rd, input logic d_rd, input logic d_wr,
                                input logic [AW-1:0] i_addr, input logic [AW-1:0] d_addr,
                                input logic [LW-1:0] wdata, input logic [LW-1:0] rdata, input int delay,
                                input logic exp_read, input logic exp_write, input logic exp_is_d,
                                input logic [AW-1:0] exp_addr, input logic [LW-1:0] exp_wdata);
        vec_t v;
        v.i_rd = i_rd; v.d_rd = d_rd; v.d_wr = d_wr;
        v.i_addr = i_addr; v.d_addr = d_addr; v.wdata = wdata; v.rdata = rdata; v.delay = delay;
        v.exp_read = exp_read; v.exp_write = exp_write; v.exp_is_d = exp_is_d;
        v.exp_addr = exp_addr; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    initial begin
        logic [AW-1:0] ia, da, ea;
        exp_t e;

        vt[0] = mk(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0, {LW{1'b0}}, {32{8'hA5}}, 5,
                   1'b1, 1'b0, 1'b0, 32'h0000_1000, {LW{1'b0}});
        vt[1] = mk(1'b0, 1'b0, 1'b1, 32'h0, 32'h8000_0040, {16{16'h1234}}, {LW{1'b0}}, 3,
                   1'b0, 1'b1, 1'b1, 32'h8000_0040, {16{16'h1234}});
        vt[2] = mk(1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_0100, {LW{1'b0}}, {32{8'h5A}}, 0,
                   1'b1, 1'b0, 1'b1, 32'h8000_0100, {LW{1'b0}});
        vt[3] = mk(1'b0, 1'b1, 1'b1, 32'h0, 32'h4000_0020, {16{16'hCAFE}}, {LW{1'b0}}, 2,
                   1'b0, 1'b1, 1'b1, 32'h4000_0020, {16{16'hCAFE}});
        vt[4] = mk(1'b1, 1'b0, 1'b0, 32'hFFFF_FFE0, 32'h0, {LW{1'b0}}, {8{32'h0BAD_F00D}}, 1,
                   1'b1, 1'b0, 1'b0, 32'hFFFF_FFE0, {LW{1'b0}});

        // Reset held two cycles with both sides requesting; I must win the first tie.
        rst = 1'b1;
        bus.imem_address = 32'h0000_2000; bus.imem_read = 1'b1;
        bus.dmem_address = 32'h8000_2000; bus.dmem_read = 1'b1; bus.dmem_write = 1'b0;
        bus.dmem_wdata = {LW{1'b0}}; bus.pmem_rdata = {LW{1'b0}}; bus.pmem_resp = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_idle("reset");
        end
        rst = 1'b0;
        @(negedge clk);
        c1("first grant read", bus.pmem_read, 1'b1);
        ca("first grant addr", bus.pmem_address, 32'h0000_2000);
        sb.push_back('{is_d: 1'b0, rdata: {8{32'h1111_2222}}});
        resp_cycle({8{32'h1111_2222}}, 1'b0);
        bus.imem_read = 1'b0;
        @(negedge clk);
        c1("loser grant read", bus.pmem_read, 1'b1);
        ca("loser grant addr", bus.pmem_address, 32'h8000_2000);
        sb.push_back('{is_d: 1'b1, rdata: {8{32'h3333_4444}}});
        resp_cycle({8{32'h3333_4444}}, 1'b1);

        // Continuous tie: grants alternate I, D, I, D with an idle cycle between each.
        ia = 32'h0000_3000; da = 32'h8000_3000;
        bus.imem_address = ia; bus.dmem_address = da;
        bus.imem_read = 1'b1; bus.dmem_read = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            ea = (t % 2 == 0) ? ia : da;
            c1("rr read", bus.pmem_read, 1'b1);
            ca("rr addr", bus.pmem_address, ea);
            e.is_d  = (t % 2 == 1);
            e.rdata = {LW{1'b0}} | LW'(t + 7);
            sb.push_back(e);
            resp_cycle(e.rdata, t == 3);
        end

        // Latch check: requester changes address and drops read mid-service.
        bus.dmem_address = 32'h8000_0080; bus.dmem_read = 1'b1;
        @(negedge clk);
        ca("latch addr", bus.pmem_address, 32'h8000_0080);
        sb.push_back('{is_d: 1'b1, rdata: {4{64'hFEED_FACE_0123_4567}}});
        bus.dmem_address = 32'hDEAD_BEE0; bus.dmem_read = 1'b0;
        repeat (2) begin
            @(negedge clk);
            c1("latch read held", bus.pmem_read, 1'b1);
            ca("latch addr held", bus.pmem_address, 32'h8000_0080);
        end
        resp_cycle({4{64'hFEED_FACE_0123_4567}}, 1'b1);

        // Reset mid-service: no response later, and last_grant returns to D.
        bus.imem_address = 32'h0000_4000; bus.imem_read = 1'b1;
        @(negedge clk);
        c1("pre-rst read", bus.pmem_read, 1'b1);
        bus.imem_read = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        c1("post-rst read", bus.pmem_read, 1'b0);
        @(negedge clk);
        bus.pmem_resp = 1'b1;
        #1;
        c1("stale imem_resp", bus.imem_resp, 1'b0);
        c1("stale dmem_resp", bus.dmem_resp, 1'b0);
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        #1;
        check_idle("after stale resp");
        bus.imem_address = 32'h0000_5000; bus.dmem_address = 32'h8000_5000;
        bus.imem_read = 1'b1; bus.dmem_read = 1'b1;
        @(negedge clk);
        ca("tie after rst addr", bus.pmem_address, 32'h0000_5000);
        sb.push_back('{is_d: 1'b0, rdata: {LW{1'b1}}});
        resp_cycle({LW{1'b1}}, 1'b1);

        // Table-driven single-requester transactions.
        for (int i = 0; i < 5; i++) begin
            bus.imem_read = vt[i].i_rd; bus.imem_address = vt[i].i_addr;
            bus.dmem_read = vt[i].d_rd; bus.dmem_write = vt[i].d_wr;
            bus.dmem_address = vt[i].d_addr; bus.dmem_wdata = vt[i].wdata;
            @(negedge clk);
            c1("vec pmem_read", bus.pmem_read, vt[i].exp_read);
            c1("vec pmem_write", bus.pmem_write, vt[i].exp_write);
            ca("vec pmem_address", bus.pmem_address, vt[i].exp_addr);
            if (vt[i].exp_write) cw("vec pmem_wdata", bus.pmem_wdata, vt[i].exp_wdata);
            sb.push_back('{is_d: vt[i].exp_is_d, rdata: vt[i].rdata});
            for (int k = 0; k < vt[i].delay; k++) begin
                c1("vec imem_resp wait", bus.imem_resp, 1'b0);
                c1("vec dmem_resp wait", bus.dmem_resp, 1'b0);
                @(negedge clk);
                c1("vec read held", bus.pmem_read, vt[i].exp_read);
                c1("vec write held", bus.pmem_write, vt[i].exp_write);
            end
            resp_cycle(vt[i].rdata, 1'b1);
        end

        n_vec++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
